// File: rtl/match_tape.sv
`default_nettype none
// ============================================================================
//  Module      : match_tape
//  Description : Trade tape capture. Each trade from the matching engine is
//                stored as {price, inter-trade gap} in a show-ahead FIFO for
//                the host, with overflow/trade counters, a large-price-move
//                pulse and a sticky circuit-breaker violation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module match_tape #(
    parameter int DEPTH   = 8,  // FIFO entries, power of two, 2..16
    parameter int JUMP_TH = 8   // price-jump threshold in ticks, 1..127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        match_valid_i,
    input  logic [7:0]  match_price_i,
    input  logic [1:0]  cb_state_i,
    input  logic        rd_ack_i,
    input  logic        err_clr_i,
    output logic        rd_valid_o,
    output logic [6:0]  rd_price_o,
    output logic [7:0]  rd_gap_o,
    output logic [4:0]  level_o,
    output logic        full_o,
    output logic [7:0]  drop_cnt_o,
    output logic [15:0] trade_cnt_o,
    output logic [6:0]  last_price_o,
    output logic        jump_pulse_o,
    output logic        pause_err_o
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] LVL_FULL = 5'(DEPTH);
    localparam logic [6:0] JUMP_MIN = 7'(JUMP_TH);
    localparam logic [1:0] CB_PAUSE = 2'b11;
    localparam logic [7:0] GAP_MAX  = 8'd255;

    // Storage: {price[6:0], gap[7:0]} per entry
    logic [14:0]   mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q,  level_d;
    logic [7:0]    gap_cnt_q, gap_cnt_d;
    logic          seen_q,   seen_d;     // a trade has occurred since reset
    logic [7:0]    drop_q,   drop_d;
    logic [15:0]   trade_q,  trade_d;
    logic [6:0]    last_q,   last_d;
    logic          jump_q,   jump_d;
    logic          pause_q,  pause_d;

    logic [6:0]    price;
    logic          empty;
    logic          is_full;
    logic          pop;
    logic          wr;
    logic          drop;
    logic [7:0]    entry_gap;
    logic [6:0]    diff;
    logic          w_unused_price_msb;

    // Bit 7 of the engine price carries no meaning for the tape
    assign w_unused_price_msb = match_price_i[7];

    assign price     = match_price_i[6:0];
    assign empty     = (level_q == 5'd0);
    assign is_full   = (level_q == LVL_FULL);
    // A pop needs an entry; a push fits if there is room or a pop frees one
    assign pop       = rd_ack_i & ~empty;
    assign wr        = match_valid_i & (~is_full | pop);
    assign drop      = match_valid_i & is_full & ~pop;
    assign entry_gap = seen_q ? gap_cnt_q : GAP_MAX;
    assign diff      = (price >= last_q) ? (price - last_q) : (last_q - price);

    // Next-state computation for pointers, level, counters and flags
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        gap_cnt_d = gap_cnt_q;
        seen_d    = seen_q;
        drop_d    = drop_q;
        trade_d   = trade_q;
        last_d    = last_q;
        jump_d    = 1'b0;
        pause_d   = pause_q;

        if (wr)  wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

        case ({wr, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase

        if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

        if (match_valid_i) begin
            gap_cnt_d = 8'd1;
            seen_d    = 1'b1;
            trade_d   = trade_q + 16'd1;
            last_d    = price;
            jump_d    = seen_q && (diff >= JUMP_MIN);
        end else if (gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + 8'd1;
        end

        // A fresh violation outranks a clear in the same cycle
        if (match_valid_i && (cb_state_i == CB_PAUSE)) begin
            pause_d = 1'b1;
        end else if (err_clr_i) begin
            pause_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            gap_cnt_q <= '0;
            seen_q    <= 1'b0;
            drop_q    <= '0;
            trade_q   <= '0;
            last_q    <= '0;
            jump_q    <= 1'b0;
            pause_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            gap_cnt_q <= gap_cnt_d;
            seen_q    <= seen_d;
            drop_q    <= drop_d;
            trade_q   <= trade_d;
            last_q    <= last_d;
            jump_q    <= jump_d;
            pause_q   <= pause_d;
        end
    end

    // Entry storage; contents are don't-care while level says empty
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= {price, entry_gap};
    end

    // Head data is masked when empty so stale storage never reaches the host
    assign rd_valid_o   = ~empty;
    assign rd_price_o   = rd_valid_o ? mem_q[rd_ptr_q][14:8] : 7'd0;
    assign rd_gap_o     = rd_valid_o ? mem_q[rd_ptr_q][7:0]  : 8'd0;
    assign level_o      = level_q;
    assign full_o       = is_full;
    assign drop_cnt_o   = drop_q;
    assign trade_cnt_o  = trade_q;
    assign last_price_o = last_q;
    assign jump_pulse_o = jump_q;
    assign pause_err_o  = pause_q;

endmodule
`default_nettype wire

// File: tb/tb_match_tape.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_tape
//  Description : Directed self-checking bench for match_tape. Expected FIFO
//                entries are queued when trades are issued; a monitor pops
//                and compares them whenever the host pops the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_match_tape;

    logic        clk;
    logic        rst_n;
    logic        match_valid;
    logic [7:0]  match_price;
    logic [1:0]  cb_state;
    logic        rd_ack;
    logic        err_clr;
    logic        rd_valid;
    logic [6:0]  rd_price;
    logic [7:0]  rd_gap;
    logic [4:0]  level;
    logic        full;
    logic [7:0]  drop_cnt;
    logic [15:0] trade_cnt;
    logic [6:0]  last_price;
    logic        jump_pulse;
    logic        pause_err;

    typedef struct packed {
        logic [6:0] p;
        logic [7:0] g;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    match_tape #(.DEPTH(8), .JUMP_TH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .match_valid_i (match_valid),
        .match_price_i (match_price),
        .cb_state_i    (cb_state),
        .rd_ack_i      (rd_ack),
        .err_clr_i     (err_clr),
        .rd_valid_o    (rd_valid),
        .rd_price_o    (rd_price),
        .rd_gap_o      (rd_gap),
        .level_o       (level),
        .full_o        (full),
        .drop_cnt_o    (drop_cnt),
        .trade_cnt_o   (trade_cnt),
        .last_price_o  (last_price),
        .jump_pulse_o  (jump_pulse),
        .pause_err_o   (pause_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [6:0] p, input logic [7:0] g);
        exp_q.push_back('{p: p, g: g});
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the edge
    task automatic step(input logic mv, input logic [7:0] pr, input logic [1:0] cb,
                        input logic ack, input logic clr);
        match_valid = mv;
        match_price = pr;
        cb_state    = cb;
        rd_ack      = ack;
        err_clr     = clr;
        @(posedge clk);
        #1;
        match_valid = 1'b0;
        match_price = 8'h00;
        cb_state    = 2'b00;
        rd_ack      = 1'b0;
        err_clr     = 1'b0;
    endtask

    // Monitor: every accepted pop must return the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && rd_ack && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 1, 0);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("pop_price", int'(rd_price), int'(e.p));
                chk("pop_gap",   int'(rd_gap),   int'(e.g));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; match_valid = 1'b0; match_price = 8'h00;
        cb_state = 2'b00; rd_ack = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_rd_valid",   int'(rd_valid), 0);
        chk("rst_level",      int'(level), 0);
        chk("rst_full",       int'(full), 0);
        chk("rst_trade_cnt",  int'(trade_cnt), 0);
        chk("rst_drop_cnt",   int'(drop_cnt), 0);
        chk("rst_last_price", int'(last_price), 0);
        chk("rst_pause_err",  int'(pause_err), 0);
        rst_n = 1'b1;

        // First trade after reset records gap 255; bit 7 of price ignored
        repeat (10) step(0, 8'h00, 2'b00, 0, 0);
        push_exp(7'h25, 8'd255);
        step(1, 8'hA5, 2'b00, 0, 0);
        chk("first_rd_valid", int'(rd_valid), 1);
        chk("first_rd_price", int'(rd_price), 'h25);
        chk("first_rd_gap",   int'(rd_gap), 255);
        chk("first_jump",     int'(jump_pulse), 0);
        chk("first_last",     int'(last_price), 'h25);
        repeat (3) step(0, 8'h00, 2'b00, 0, 0);
        push_exp(7'h40, 8'd4);
        step(1, 8'h40, 2'b00, 0, 0);
        chk("second_level",   int'(level), 2);
        chk("second_head",    int'(rd_price), 'h25);
        repeat (2) step(0, 8'h00, 2'b00, 1, 0);
        chk("drain1_level",   int'(level), 0);

        // Fresh reset, then overflow: 9 trades into 8 entries
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) push_exp(7'(i), (i == 1) ? 8'd255 : 8'd1);
            step(1, 8'(i), 2'b00, 0, 0);
        end
        chk("ovf_full",      int'(full), 1);
        chk("ovf_level",     int'(level), 8);
        chk("ovf_drop",      int'(drop_cnt), 1);
        chk("ovf_trade",     int'(trade_cnt), 9);
        chk("ovf_head",      int'(rd_price), 1);
        chk("ovf_last",      int'(last_price), 9);

        // Push and pop together while full
        push_exp(7'h50, 8'd1);
        step(1, 8'h50, 2'b00, 1, 0);
        chk("pp_level",      int'(level), 8);
        chk("pp_full",       int'(full), 1);
        chk("pp_drop",       int'(drop_cnt), 1);
        chk("pp_head",       int'(rd_price), 2);
        chk("pp_jump",       int'(jump_pulse), 1);
        repeat (8) step(0, 8'h00, 2'b00, 1, 0);
        chk("drain2_level",  int'(level), 0);
        chk("drain2_valid",  int'(rd_valid), 0);

        // Push with pop while empty: push only; then jump threshold cases
        push_exp(7'h30, 8'd9);
        step(1, 8'h30, 2'b00, 1, 0);
        chk("pe_level",      int'(level), 1);
        chk("jmp_last30",    int'(last_price), 'h30);
        push_exp(7'h27, 8'd1);
        step(1, 8'h27, 2'b00, 0, 0);
        chk("jmp_27",        int'(jump_pulse), 1);
        step(0, 8'h00, 2'b00, 0, 0);
        chk("jmp_27_once",   int'(jump_pulse), 0);
        push_exp(7'h29, 8'd2);
        step(1, 8'h29, 2'b00, 0, 0);
        chk("jmp_29",        int'(jump_pulse), 0);
        push_exp(7'h31, 8'd1);
        step(1, 8'h31, 2'b00, 0, 0);
        chk("jmp_diff8",     int'(jump_pulse), 1);
        repeat (4) step(0, 8'h00, 2'b00, 1, 0);

        // Sticky pause error
        push_exp(7'h2A, 8'd5);
        step(1, 8'h2A, 2'b11, 0, 0);
        chk("pause_set",     int'(pause_err), 1);
        chk("jmp_diff7",     int'(jump_pulse), 0);
        step(0, 8'h00, 2'b00, 0, 0);
        chk("pause_hold",    int'(pause_err), 1);
        step(0, 8'h00, 2'b00, 0, 1);
        chk("pause_clr",     int'(pause_err), 0);
        step(0, 8'h00, 2'b11, 0, 0);
        chk("pause_nomatch", int'(pause_err), 0);
        push_exp(7'h2B, 8'd4);
        step(1, 8'h2B, 2'b11, 0, 1);
        chk("pause_setwins", int'(pause_err), 1);
        repeat (2) step(0, 8'h00, 2'b00, 1, 0);

        // Long idle saturates the gap
        repeat (300) step(0, 8'h00, 2'b00, 0, 0);
        push_exp(7'h11, 8'd255);
        step(1, 8'h11, 2'b00, 0, 0);
        chk("idle_gap",      int'(rd_gap), 255);
        step(0, 8'h00, 2'b00, 1, 0);
        step(0, 8'h00, 2'b00, 1, 0);
        chk("ackempty_level", int'(level), 0);
        chk("ackempty_valid", int'(rd_valid), 0);
        chk("ackempty_drop",  int'(drop_cnt), 1);
        chk("ackempty_trade", int'(trade_cnt), 17);
        chk("ackempty_last",  int'(last_price), 'h11);

        // Reset with entries pending discards them at once
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 2'b00, 0, 0);
        chk("pre_rst_level", int'(level), 5);
        rst_n = 1'b0;
        #1;
        chk("arst_level",    int'(level), 0);
        chk("arst_valid",    int'(rd_valid), 0);
        chk("arst_price",    int'(rd_price), 0);
        chk("arst_trade",    int'(trade_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(7'h33, 8'd255);
        step(1, 8'h33, 2'b00, 0, 0);
        chk("post_rst_price", int'(rd_price), 'h33);
        chk("post_rst_gap",   int'(rd_gap), 255);
        chk("post_rst_jump",  int'(jump_pulse), 0);
        chk("post_rst_level", int'(level), 1);
        step(0, 8'h00, 2'b00, 1, 0);
        step(0, 8'h00, 2'b00, 0, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_tape.md
MATCH_TAPE -- requirements
Module: match_tape

Parameters
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of FIFO entries; the value SHALL be a power of two in the range 2..16.
REQ-002 SHALL have parameter JUMP_TH, default 8, meaning the price-jump threshold in ticks (1..127).

Interface
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 match_valid  input  1  one-cycle trade pulse from the matching engine.
REQ-006 match_price  input  8  trade price; bit 7 ignored; price = match_price[6:0].
REQ-007 cb_state  input  2  circuit-breaker mode from the matching engine (11 = PAUSE).
REQ-008 rd_ack  input  1  host pop strobe.
REQ-009 err_clr  input  1  clears the sticky error flags.
REQ-010 rd_valid  output  1  FIFO non-empty; head entry presented.
REQ-011 rd_price  output  7  head entry price.
REQ-012 rd_gap  output  8  head entry inter-trade gap in cycles.
REQ-013 level  output  5  current entry count, 0..DEPTH.
REQ-014 full  output  1  level == DEPTH.
REQ-015 drop_cnt  output  8  trades lost to overflow; saturates at 255.
REQ-016 trade_cnt  output  16  total trades accepted or dropped; wraps at 2^16.
REQ-017 last_price  output  7  price of the most recent trade.
REQ-018 jump_pulse  output  1  one-cycle flag for a large price move.
REQ-019 pause_err  output  1  sticky flag: trade seen while cb_state == 11.

Function
REQ-020 SHALL operate as a show-ahead FIFO: rd_price and rd_gap reflect the head entry whenever rd_valid = 1.
REQ-021 SHALL pop the head entry on a cycle where rd_ack = 1 and rd_valid = 1; rd_ack while empty SHALL be ignored with no state change.
REQ-022 SHALL push {price, gap} on a cycle where match_valid = 1; the entry SHALL be visible on rd_* at cycle N+1 for a push at cycle N.
REQ-023 When full with no pop, a push SHALL be discarded and drop_cnt incremented, saturating at 255; FIFO contents SHALL be unchanged.
REQ-024 Simultaneous push and pop while full SHALL both succeed; level stays at DEPTH; drop_cnt is unchanged.
REQ-025 Simultaneous push and pop while empty SHALL push only; the pop is ignored.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; level SHALL be a separate counter or extra-bit pointer difference, never ambiguous at full or empty.
REQ-027 gap_cnt (8 bits, internal) SHALL increment on every cycle without match_valid, saturating at 255.
REQ-028 On a match, the entry gap SHALL equal gap_cnt, and gap_cnt SHALL be set to 1 on the next cycle.
REQ-029 The first trade after reset SHALL record gap 255 regardless of gap_cnt.
REQ-030 trade_cnt SHALL increment on every match_valid, including dropped trades.
REQ-031 last_price SHALL update on every match_valid, including dropped trades.
REQ-032 jump_pulse SHALL assert at N+1 for a match at N if a prior trade exists and |price - last_price| >= JUMP_TH, compared as 7-bit unsigned magnitude with no wrap.
REQ-033 pause_err SHALL set when match_valid = 1 and cb_state = 2'b11, and SHALL hold until err_clr.
REQ-034 If err_clr and a set condition occur in the same cycle, the set condition SHALL win.
REQ-035 All outputs SHALL be registered or derived only from registered state, with no combinational path from inputs to outputs.

Reset
REQ-036 On rst_n low, all outputs SHALL reset asynchronously to 0: rd_valid, rd_price, rd_gap, level, full, drop_cnt, trade_cnt, last_price, jump_pulse, pause_err.
REQ-037 Reset SHALL also return the internal state to its initial values: pointers 0, gap_cnt 0, the first-trade flag cleared.
REQ-038 Reset SHALL discard FIFO contents mid-operation; no entry SHALL be visible after release.
REQ-039 The first clock edge after release SHALL behave as a normal cycle.

Verification
REQ-040 Bench SHALL cover: reset; match price 0x25 at cycle 10 -> rd_valid=1, rd_price=0x25, rd_gap=255 at cycle 11; a second match at cycle 14 pushes gap=4.
REQ-041 Bench SHALL cover: 9 matches with no rd_ack (DEPTH 8) -> full=1, level=8, drop_cnt=1, trade_cnt=9; pops return the first 8 prices in order.
REQ-042 Bench SHALL cover: full FIFO with match and rd_ack in the same cycle -> level stays 8, drop_cnt unchanged, head advances, the new price appears as the tail.
REQ-043 Bench SHALL cover: last_price=0x30 then a match at 0x27 -> jump_pulse=1 for exactly one cycle; a match at 0x29 -> jump_pulse=0.
REQ-044 Bench SHALL cover: match_valid with cb_state=11 -> pause_err=1 persists; err_clr -> 0; err_clr coincident with a new violation -> remains 1.
REQ-045 Bench SHALL cover: 300 idle cycles then a match -> gap=255; rd_ack while empty -> no change; rst_n low with 5 entries -> level=0 and rd_valid=0 immediately.
